// File: rtl/hazard_control_unit.sv
// Hazard control for a five-stage pipeline: load-use interlock, taken-branch
// flush, and a memory-wait freeze. The memory freeze can interrupt the branch
// redirect cycle; in that case the redirect is remembered and replayed once
// memory completes. The pipeline control outputs are combinational so the
// stall or flush acts in the same cycle the condition is seen.
module hazard_control_unit #(
    parameter logic [3:0] R_ZERO      = 4'd0,
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ifid_rs,
    input  logic [3:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic [3:0]  idex_rd,
    input  logic        idex_memread,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        flush_pend_r;
    logic        flush_pend_next_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_inc_s;
    logic        mem_timeout_r;
    logic [15:0] stall_cnt_r;
    logic        mem_stall_s;
    logic        load_use_s;

    // A load in ID/EX whose destination feeds the instruction in IF/ID.
    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [3:0] rd,
        input logic [3:0] rs,
        input logic [3:0] rt,
        input logic       uses_rt,
        input logic [3:0] zero_reg
    );
        return memread && (rd != zero_reg) &&
               ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    assign mem_stall_s    = mem_req && !mem_ready;
    assign load_use_s     = load_use_hazard(idex_memread, idex_rd, ifid_rs,
                                            ifid_rt, ifid_uses_rt, R_ZERO);
    assign wait_cnt_inc_s = wait_cnt_r + 8'd1;

    // Pipeline control outputs and next-state selection.
    always_comb begin
        pc_write          = 1'b1;
        ifid_write        = 1'b1;
        ifid_flush        = 1'b0;
        idex_flush        = 1'b0;
        pipe_hold         = 1'b0;
        state_next_s      = state_r;
        flush_pend_next_s = flush_pend_r;
        if (!rst_n) begin
            state_next_s      = RUN;
            flush_pend_next_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold    = 1'b1;
                        state_next_s = MEM_WAIT;
                    end else if (branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        state_next_s = FLUSH;
                    end else if (load_use_s) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_flush   = 1'b1;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FLUSH: begin
                    if (mem_stall_s) begin
                        pc_write          = 1'b0;
                        ifid_write        = 1'b0;
                        pipe_hold         = 1'b1;
                        flush_pend_next_s = 1'b1;
                        state_next_s      = MEM_WAIT;
                    end else begin
                        ifid_flush   = 1'b1;
                        state_next_s = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        pipe_hold  = 1'b1;
                    end else begin
                        state_next_s      = flush_pend_r ? FLUSH : RUN;
                        flush_pend_next_s = 1'b0;
                    end
                end
                default: begin
                    state_next_s      = RUN;
                    flush_pend_next_s = 1'b0;
                end
            endcase
        end
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= RUN;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            flush_pend_r <= flush_pend_next_s;
        end
    end

    // Memory wait length counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r    <= 8'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            if ((state_r != MEM_WAIT) && (state_next_s == MEM_WAIT)) begin
                wait_cnt_r <= 8'd0;
            end else if ((state_r == MEM_WAIT) && (wait_cnt_r != 8'hFF)) begin
                wait_cnt_r <= wait_cnt_inc_s;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_r == MEM_WAIT) && (wait_cnt_r != 8'hFF) &&
                (wait_cnt_inc_s == MEM_TIMEOUT)) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (!pc_write && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mem_timeout  = mem_timeout_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed vectors with hand-computed
// expectations, plus a cycle-by-cycle reference model of the pipeline-control
// rules checked on every falling edge.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ifid_rs, ifid_rt, idex_rd;
    logic        ifid_uses_rt, idex_memread, branch_taken, mem_req, mem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout;
    logic [15:0] stall_cycles;
    logic [4:0]  outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold};

    hazard_control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_rd      (idex_rd),
        .idex_memread (idex_memread),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .pipe_hold    (pipe_hold),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory outstanding flag, owed redirect cycles,
    // wait length, sticky timeout and stall total.
    bit m_valid   = 1'b0;
    bit m_waiting = 1'b0;
    int m_owed    = 0;
    int m_waitlen = 0;
    bit m_timeout = 1'b0;
    int m_stalls  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!m_valid) begin
                if (rst_n === 1'b0) begin
                    m_valid = 1'b1;
                end
            end else begin
                logic [4:0] exp_o;
                bit blocked;
                bit lu;
                check("model_timeout", {15'd0, mem_timeout}, {15'd0, m_timeout});
                check("model_stalls", stall_cycles, m_stalls[15:0]);
                lu = idex_memread && (idex_rd != 4'd0) &&
                     ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
                blocked = m_waiting ? !mem_ready : (mem_req && !mem_ready);
                if (!rst_n) begin
                    exp_o     = 5'b11000;
                    m_waiting = 1'b0;
                    m_owed    = 0;
                    m_waitlen = 0;
                    m_timeout = 1'b0;
                end else if (blocked) begin
                    exp_o = 5'b00001;
                    if (m_waiting) begin
                        m_waitlen++;
                    end else begin
                        m_waitlen = 0;
                    end
                    m_waiting = 1'b1;
                end else if (m_waiting) begin
                    exp_o     = 5'b11000;
                    m_waitlen++;
                    m_waiting = 1'b0;
                end else if (m_owed > 0) begin
                    exp_o  = 5'b11100;
                    m_owed = 0;
                end else if (branch_taken) begin
                    exp_o  = 5'b11110;
                    m_owed = 1;
                end else if (lu) begin
                    exp_o = 5'b00010;
                end else begin
                    exp_o = 5'b11000;
                end
                if (rst_n && (m_waitlen >= 255) && (blocked || exp_o == 5'b11000) &&
                    (m_waiting || !blocked) && m_waitlen > 0) begin
                    m_timeout = 1'b1;
                end
                check("model_outs", {11'd0, outs}, {11'd0, exp_o});
                if (!rst_n) begin
                    m_stalls = 0;
                end else if (!exp_o[4] && m_stalls < 65535) begin
                    m_stalls++;
                end
            end
        end
    end

    task automatic set_in(input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                          input logic [3:0] rd, input logic mr, input logic br,
                          input logic rq, input logic rdy);
        ifid_rs      = rs;
        ifid_rt      = rt;
        ifid_uses_rt = urt;
        idex_rd      = rd;
        idex_memread = mr;
        branch_taken = br;
        mem_req      = rq;
        mem_ready    = rdy;
    endtask

    task automatic idle();
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check the control outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string name, input logic [4:0] exp);
        #3;
        check(name, {11'd0, outs}, {11'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("reset_stall", stall_cycles, 16'd0);
        check("reset_timeout", {15'd0, mem_timeout}, 16'd0);
        cyc("reset_outs", 5'b11000);

        // load-use through rs, then through rt
        set_in(4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs", 5'b00010);
        idle();
        check("lu_rs_stall", stall_cycles, 16'd1);
        cyc("lu_rs_after", 5'b11000);
        set_in(4'd2, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rt", 5'b00010);
        idle();
        check("lu_rt_stall", stall_cycles, 16'd2);
        cyc("lu_rt_after", 5'b11000);

        // no-hazard cases
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("nohz_rd0", 5'b11000);
        set_in(4'd1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("nohz_rt_unused", 5'b11000);
        set_in(4'd3, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("nohz_not_load", 5'b11000);
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("mem_ready_now", 5'b11000);
        check("nohz_stall", stall_cycles, 16'd2);

        // taken branch overrides a load-use hazard
        set_in(4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("br_c0", 5'b11110);
        idle();
        cyc("br_c1", 5'b11100);
        cyc("br_c2", 5'b11000);
        check("br_stall", stall_cycles, 16'd2);

        // four-cycle memory wait; branch and load-use are masked inside it
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                set_in(4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
            end else begin
                set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            cyc("memwait_hold", 5'b00001);
        end
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("memwait_release", 5'b11000);
        idle();
        check("memwait_stall", stall_cycles, 16'd6);
        cyc("memwait_no_replay", 5'b11000);

        // memory wait preempts the redirect cycle, which is replayed afterwards
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("pf_branch", 5'b11110);
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("pf_hold0", 5'b00001);
        cyc("pf_hold1", 5'b00001);
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("pf_ready", 5'b11000);
        idle();
        cyc("pf_replay", 5'b11100);
        cyc("pf_done", 5'b11000);
        check("pf_stall", stall_cycles, 16'd8);

        // timeout after 256 cycles of waiting, then reset clears everything
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 257; i++) begin
            if (i == 255) begin
                check("to_not_yet", {15'd0, mem_timeout}, 16'd0);
            end
            if (i == 256) begin
                check("to_set", {15'd0, mem_timeout}, 16'd1);
                check("to_stall", stall_cycles, 16'd264);
            end
            cyc("to_hold", 5'b00001);
        end
        check("to_sticky", {15'd0, mem_timeout}, 16'd1);
        rst_n = 1'b0;
        cyc("rst_outs", 5'b11000);
        rst_n = 1'b1;
        idle();
        check("rst_timeout", {15'd0, mem_timeout}, 16'd0);
        check("rst_stall", stall_cycles, 16'd0);
        cyc("post_rst", 5'b11000);

        // reset during the redirect cycle abandons it
        set_in(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rf_branch", 5'b11110);
        idle();
        rst_n = 1'b0;
        cyc("rf_in_reset", 5'b11000);
        rst_n = 1'b1;
        cyc("rf_no_replay", 5'b11000);

        // load-use works normally after reset
        set_in(4'd4, 4'd4, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("final_lu", 5'b00010);
        idle();
        check("final_stall", stall_cycles, 16'd1);
        cyc("final_idle", 5'b11000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
